rv32i_axil_arbiter: RTL and testbench
=====================================

Name: rv32i_axil_arbiter

Overview:
- Shares one AXI4-Lite slave port between NUM_MASTERS AXI4-Lite masters, for example the core data bridge (master 0) and a debug/DMA engine (master 1).
- Sits between the masters and the peripheral/memory fabric.
- Allows one transaction in flight system-wide.
- Uses round-robin arbitration and holds the grant until that transaction's response handshake completes.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axi_aw{addr,prot,valid} in / s_axi_awready out  NUM_MASTERS×{ADDR_W,3,1} / NUM_MASTERS  per-master write address channel, flattened, master i at slice i.
- s_axi_w{data,strb,valid} in / s_axi_wready out  NUM_MASTERS×{DATA_W,DATA_W/8,1} / NUM_MASTERS  per-master write data channel.
- s_axi_b{resp,valid} out / s_axi_bready in  NUM_MASTERS×{2,1} / NUM_MASTERS  per-master write response channel.
- s_axi_ar{addr,prot,valid} in / s_axi_arready out  NUM_MASTERS×{ADDR_W,3,1} / NUM_MASTERS  per-master read address channel.
- s_axi_r{data,resp,valid} out / s_axi_rready in  NUM_MASTERS×{DATA_W,2,1} / NUM_MASTERS  per-master read data channel.
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  mirror  single-port widths  downstream AXI4-Lite port.
- arb_grant  out  NUM_MASTERS  one-hot current owner; 0 when idle.
- arb_busy  out  1  transaction in progress.

Behaviour:
- Request: master i requests when s_axi_arvalid[i] or s_axi_awvalid[i] is high.
- FSM states: S_IDLE, S_RD, S_WR.
- S_IDLE:
  - Evaluate requests with the round-robin pointer. Search starts at last_grant+1 mod NUM_MASTERS.
  - Register the winner into grant_r and go to S_RD if the winner's arvalid is high, else S_WR. Read wins over write within the same master.
  - No channel is forwarded in S_IDLE. Arbitration latency is 1 cycle.
- S_RD:
  - AR and R are forwarded combinationally between the granted master and the m_ side.
  - Return to S_IDLE on the m_axi_rvalid && m_axi_rready handshake. last_grant <= grant_r.
- S_WR:
  - AW, W and B are forwarded combinationally. AW and W may complete in either order or the same cycle; no tracking is needed because they pass through.
  - Return to S_IDLE on the m_axi_bvalid && m_axi_bready handshake.
- Non-granted masters see all ready outputs and s_axi_bvalid/s_axi_rvalid at 0. The granted master's other-direction channels also see 0: AR is blocked in S_WR and AW/W are blocked in S_RD.
- m_ side in S_IDLE: all valid outputs 0, m_axi_bready/m_axi_rready 0, address/data outputs 0.
- Response payload (rdata, rresp, bresp) is broadcast to all masters; only the valid bit is steered.
- Back-to-back transactions need at least 1 idle cycle between them (response cycle, then arbitration cycle).
- Single requester: gets the grant every time; no starvation.
- All masters requesting: strict rotation 0,1,…,N-1,0.
- Reset values:
  - state=S_IDLE, grant_r=0, last_grant=NUM_MASTERS-1 (so master 0 wins the first tie).
  - All outputs are 0 on reset.
- Reset mid-transaction: async reset forces S_IDLE and drops every valid/ready immediately. A downstream slave reset is the system's responsibility.
- A master that deasserts valid before its handshake violates AXI and is not guarded.

Optional Feature:
- Macro: RV32I_AXIL_ARB_PERF_EN.
- When defined:
  - Adds output perf_grants of width NUM_MASTERS×32: per-master count of completed transactions, incremented on the response handshake.
  - Adds output perf_wait of width NUM_MASTERS×32: per-master count of cycles with the request high but not granted.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package rv32i_axil_pkg holds:
  - arbiter state encodings S_IDLE=2'd0, S_RD=2'd1, S_WR=2'd2;
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10;
  - AXIL_PROT_DEFAULT=3'b000.
- One sub-module, rv32i_rr_arbiter: a combinational round-robin pick from req and last_grant to a one-hot grant. It is reusable by the instruction-side fabric.

Test Plan:
- Reset, then master 0 issues a read of 0x0000_1000 with the slave returning 0xDEADBEEF.
  - arb_grant=01 one cycle after arvalid.
  - m_axi_araddr=0x1000.
  - s_axi_rdata[0]=0xDEADBEEF with rvalid[0] only.
  - arb_busy drops the cycle after the R handshake.
- Master 0 and master 1 both write continuously (master 0: 0x10 ← 0x11111111; master 1: 0x20 ← 0x22222222).
  - m_ writes alternate 0x10, 0x20, 0x10, …
  - Each master's awready stays 0 while the other owns the bus.
- Master 1 asserts arvalid and awvalid together.
  - The read is served first (state S_RD).
  - The write is granted on the next arbitration only if master 0 is idle.
- Slave delays wready 5 cycles after awready (0x40 ← 0xA5A5A5A5, wstrb=4'b0011).
  - The grant is held through 5 cycles plus the B handshake.
  - m_axi_wstrb=0011.
  - bresp=OKAY is delivered to the owner only.
- Assert rst_n low while in S_WR with m_axi_awvalid=1.
  - All valid/ready outputs and arb_grant are 0 in the same cycle.
  - After release, master 0 wins the first arbitration.
- With RV32I_AXIL_ARB_PERF_EN, run 3 reads by master 0 and 2 writes by master 1, with master 0 contending for one cycle.
  - perf_grants = {2, 3} (master 1, master 0).
  - perf_wait[0] ≥ 1.

Source files
------------

// File: rtl/rv32i_axil_pkg.sv
// rv32i_axil_pkg
// Shared constants for the AXI4-Lite arbiter slice: arbiter state encodings,
// AXI response codes, the default protection value and a saturating
// increment used by the optional performance counters.
package rv32i_axil_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

    localparam int PERF_CNT_W = 32;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rv32i_rr_arbiter.sv
// rv32i_rr_arbiter
// Combinational round-robin pick. The search starts one position after
// last_grant and wraps, so the previous winner has the lowest priority.
// Ports:
//   req         in   N      request vector
//   last_grant  in   IDX_W  index of the previous winner
//   grant       out  N      one-hot winner (0 when no request)
//   grant_idx   out  IDX_W  index of the winner
//   grant_valid out  1      at least one request present
module rv32i_rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N);
            if (!grant_valid && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv32i_axil_arbiter.sv
// rv32i_axil_arbiter
// Shares one downstream AXI4-Lite port between NUM_MASTERS upstream masters.
// One transaction is in flight at a time; the owner is picked round-robin in
// S_IDLE and keeps the bus until its R or B handshake completes.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_axi_{aw,w,b,ar,r}*        per-master AXI4-Lite slave channels,
//                               flattened, master i at slice i
//   m_axi_{aw,w,b,ar,r}*        downstream AXI4-Lite master port
//   arb_grant                   one-hot current owner, 0 when idle
//   arb_busy                    transaction in progress
//   perf_grants, perf_wait      only with RV32I_AXIL_ARB_PERF_EN defined:
//                               per-master 32-bit saturating counters of
//                               completed transactions / cycles waiting
//
// state  | meaning
// S_IDLE | arbitrate, nothing forwarded
// S_RD   | AR and R passed through for the owner
// S_WR   | AW, W and B passed through for the owner
module rv32i_axil_arbiter
    import rv32i_axil_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [NUM_MASTERS*ADDR_W-1:0] s_axi_awaddr,
    input  logic [NUM_MASTERS*3-1:0]      s_axi_awprot,
    input  logic [NUM_MASTERS-1:0]        s_axi_awvalid,
    output logic [NUM_MASTERS-1:0]        s_axi_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0] s_axi_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] s_axi_wstrb,
    input  logic [NUM_MASTERS-1:0]        s_axi_wvalid,
    output logic [NUM_MASTERS-1:0]        s_axi_wready,
    output logic [NUM_MASTERS*2-1:0]      s_axi_bresp,
    output logic [NUM_MASTERS-1:0]        s_axi_bvalid,
    input  logic [NUM_MASTERS-1:0]        s_axi_bready,
    input  logic [NUM_MASTERS*ADDR_W-1:0] s_axi_araddr,
    input  logic [NUM_MASTERS*3-1:0]      s_axi_arprot,
    input  logic [NUM_MASTERS-1:0]        s_axi_arvalid,
    output logic [NUM_MASTERS-1:0]        s_axi_arready,
    output logic [NUM_MASTERS*DATA_W-1:0] s_axi_rdata,
    output logic [NUM_MASTERS*2-1:0]      s_axi_rresp,
    output logic [NUM_MASTERS-1:0]        s_axi_rvalid,
    input  logic [NUM_MASTERS-1:0]        s_axi_rready,

    output logic [ADDR_W-1:0]             m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [DATA_W-1:0]             m_axi_wdata,
    output logic [DATA_W/8-1:0]           m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [ADDR_W-1:0]             m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [DATA_W-1:0]             m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,

`ifdef RV32I_AXIL_ARB_PERF_EN
    output logic [NUM_MASTERS*32-1:0]     perf_grants,
    output logic [NUM_MASTERS*32-1:0]     perf_wait,
`endif
    output logic [NUM_MASTERS-1:0]        arb_grant,
    output logic                          arb_busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [1:0]             state;
    logic [NUM_MASTERS-1:0] grant_r;
    logic [IDX_W-1:0]       grant_idx_r;
    logic [IDX_W-1:0]       last_grant;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   rd_done;
    logic                   wr_done;

    assign req = s_axi_arvalid | s_axi_awvalid;

    rv32i_rr_arbiter #(
        .N (NUM_MASTERS)
    ) u_rr (
        .req         (req),
        .last_grant  (last_grant),
        .grant       (pick),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    // m_axi_rready / m_axi_bready are already zero outside their state.
    assign rd_done = (state == S_RD) && m_axi_rvalid && m_axi_rready;
    assign wr_done = (state == S_WR) && m_axi_bvalid && m_axi_bready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant_r     <= '0;
            grant_idx_r <= '0;
            last_grant  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_r     <= pick;
                        grant_idx_r <= pick_idx;
                        // a master offering both directions is served read first
                        state       <= s_axi_arvalid[pick_idx] ? S_RD : S_WR;
                    end
                end
                S_RD: begin
                    if (rd_done) begin
                        state      <= S_IDLE;
                        grant_r    <= '0;
                        last_grant <= grant_idx_r;
                    end
                end
                S_WR: begin
                    if (wr_done) begin
                        state      <= S_IDLE;
                        grant_r    <= '0;
                        last_grant <= grant_idx_r;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    // Pass-through muxing. Everything defaults to zero so that idle, the
    // opposite direction and non-owners all see quiet channels; the response
    // payload is broadcast only while its direction is active.
    always_comb begin
        s_axi_awready = '0;
        s_axi_wready  = '0;
        s_axi_bresp   = '0;
        s_axi_bvalid  = '0;
        s_axi_arready = '0;
        s_axi_rdata   = '0;
        s_axi_rresp   = '0;
        s_axi_rvalid  = '0;
        m_axi_awaddr  = '0;
        m_axi_awprot  = AXIL_PROT_DEFAULT;
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arprot  = AXIL_PROT_DEFAULT;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            S_RD: begin
                m_axi_araddr               = s_axi_araddr[grant_idx_r*ADDR_W +: ADDR_W];
                m_axi_arprot               = s_axi_arprot[grant_idx_r*3 +: 3];
                m_axi_arvalid              = s_axi_arvalid[grant_idx_r];
                s_axi_arready[grant_idx_r] = m_axi_arready;
                s_axi_rvalid[grant_idx_r]  = m_axi_rvalid;
                m_axi_rready               = s_axi_rready[grant_idx_r];
                s_axi_rdata                = {NUM_MASTERS{m_axi_rdata}};
                s_axi_rresp                = {NUM_MASTERS{m_axi_rresp}};
            end
            S_WR: begin
                m_axi_awaddr               = s_axi_awaddr[grant_idx_r*ADDR_W +: ADDR_W];
                m_axi_awprot               = s_axi_awprot[grant_idx_r*3 +: 3];
                m_axi_awvalid              = s_axi_awvalid[grant_idx_r];
                s_axi_awready[grant_idx_r] = m_axi_awready;
                m_axi_wdata                = s_axi_wdata[grant_idx_r*DATA_W +: DATA_W];
                m_axi_wstrb                = s_axi_wstrb[grant_idx_r*STRB_W +: STRB_W];
                m_axi_wvalid               = s_axi_wvalid[grant_idx_r];
                s_axi_wready[grant_idx_r]  = m_axi_wready;
                s_axi_bvalid[grant_idx_r]  = m_axi_bvalid;
                m_axi_bready               = s_axi_bready[grant_idx_r];
                s_axi_bresp                = {NUM_MASTERS{m_axi_bresp}};
            end
            default: begin
            end
        endcase
    end

    assign arb_grant = grant_r;
    assign arb_busy  = (state != S_IDLE);

`ifdef RV32I_AXIL_ARB_PERF_EN
    // grant_r is zero in S_IDLE, so the arbitration cycle counts as waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grants <= '0;
            perf_wait   <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if ((rd_done || wr_done) && grant_r[i])
                    perf_grants[i*32 +: 32] <= sat_inc(perf_grants[i*32 +: 32]);
                if (req[i] && !grant_r[i])
                    perf_wait[i*32 +: 32] <= sat_inc(perf_wait[i*32 +: 32]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_axil_arbiter.sv
// tb_rv32i_axil_arbiter
// Directed bench for rv32i_axil_arbiter with two masters. The bench plays
// both the upstream masters and the downstream slave. Performance counter
// checks are compiled only with RV32I_AXIL_ARB_PERF_EN defined.
module tb_rv32i_axil_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk;
    logic rst_n;

    logic [N*AW-1:0] s_axi_awaddr;
    logic [N*3-1:0]  s_axi_awprot;
    logic [N-1:0]    s_axi_awvalid;
    logic [N-1:0]    s_axi_awready;
    logic [N*DW-1:0] s_axi_wdata;
    logic [N*SW-1:0] s_axi_wstrb;
    logic [N-1:0]    s_axi_wvalid;
    logic [N-1:0]    s_axi_wready;
    logic [N*2-1:0]  s_axi_bresp;
    logic [N-1:0]    s_axi_bvalid;
    logic [N-1:0]    s_axi_bready;
    logic [N*AW-1:0] s_axi_araddr;
    logic [N*3-1:0]  s_axi_arprot;
    logic [N-1:0]    s_axi_arvalid;
    logic [N-1:0]    s_axi_arready;
    logic [N*DW-1:0] s_axi_rdata;
    logic [N*2-1:0]  s_axi_rresp;
    logic [N-1:0]    s_axi_rvalid;
    logic [N-1:0]    s_axi_rready;

    logic [AW-1:0]   m_axi_awaddr;
    logic [2:0]      m_axi_awprot;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [DW-1:0]   m_axi_wdata;
    logic [SW-1:0]   m_axi_wstrb;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;
    logic [AW-1:0]   m_axi_araddr;
    logic [2:0]      m_axi_arprot;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [DW-1:0]   m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rvalid;
    logic            m_axi_rready;

`ifdef RV32I_AXIL_ARB_PERF_EN
    logic [N*32-1:0] perf_grants;
    logic [N*32-1:0] perf_wait;
`endif
    logic [N-1:0]    arb_grant;
    logic            arb_busy;

    int checks   = 0;
    int failures = 0;

    rv32i_axil_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
`ifdef RV32I_AXIL_ARB_PERF_EN
        .perf_grants   (perf_grants),
        .perf_wait     (perf_wait),
`endif
        .arb_grant     (arb_grant),
        .arb_busy      (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        s_axi_awaddr  = '0; s_axi_awprot = '0; s_axi_awvalid = '0;
        s_axi_wdata   = '0; s_axi_wstrb  = '0; s_axi_wvalid  = '0;
        s_axi_bready  = '0;
        s_axi_araddr  = '0; s_axi_arprot = '0; s_axi_arvalid = '0;
        s_axi_rready  = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bresp   = 2'b00; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rdata   = '0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_read(input int m, input logic [31:0] addr, input logic [31:0] data);
        bit found;
        @(posedge clk); #1;
        s_axi_arvalid[m]        = 1'b1;
        s_axi_araddr[m*AW +: AW] = addr;
        s_axi_rready[m]         = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_axi_arvalid) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL run_read_timeout: master %0d arvalid never forwarded", m);
        end
        m_axi_arready = 1'b1;
        @(posedge clk); #1;
        s_axi_arvalid[m] = 1'b0;
        m_axi_arready    = 1'b0;
        m_axi_rvalid     = 1'b1;
        m_axi_rdata      = data;
        @(posedge clk); #1;
        m_axi_rvalid    = 1'b0;
        s_axi_rready[m] = 1'b0;
    endtask

    task automatic run_write(input int m, input logic [31:0] addr, input logic [31:0] data);
        bit found;
        @(posedge clk); #1;
        s_axi_awvalid[m]         = 1'b1;
        s_axi_awaddr[m*AW +: AW] = addr;
        s_axi_wvalid[m]          = 1'b1;
        s_axi_wdata[m*DW +: DW]  = data;
        s_axi_wstrb[m*SW +: SW]  = 4'hF;
        s_axi_bready[m]          = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_axi_awvalid) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL run_write_timeout: master %0d awvalid never forwarded", m);
        end
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid[m] = 1'b0;
        s_axi_wvalid[m]  = 1'b0;
        m_axi_awready    = 1'b0;
        m_axi_wready     = 1'b0;
        m_axi_bvalid     = 1'b1;
        @(posedge clk); #1;
        m_axi_bvalid    = 1'b0;
        s_axi_bready[m] = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        // slave side noisy during reset: nothing may leak through
        m_axi_rvalid  = 1'b1;
        m_axi_arready = 1'b1;
        m_axi_rdata   = 32'hCAFE_F00D;
        s_axi_arvalid = 2'b11;
        s_axi_rready  = 2'b11;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (arb_grant !== 2'b00 || arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_grant: grant=%b busy=%b expected 00/0", arb_grant, arb_busy);
        end
        checks++;
        if (s_axi_arready !== 2'b00 || s_axi_rvalid !== 2'b00 || m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshakes: arready=%b rvalid=%b m_arvalid=%b m_rready=%b expected all 0",
                     s_axi_arready, s_axi_rvalid, m_axi_arvalid, m_axi_rready);
        end
        checks++;
        if (s_axi_rdata !== 64'h0 || m_axi_araddr !== 32'h0) begin
            failures++;
            $display("FAIL reset_payload: rdata=%h araddr=%h expected 0", s_axi_rdata, m_axi_araddr);
        end
        apply_reset();
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        s_axi_arvalid = 2'b01;
        s_axi_araddr[31:0] = 32'h0000_1000;
        s_axi_rready  = 2'b01;
        @(negedge clk);
        checks++;
        if (arb_grant !== 2'b00 || m_axi_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL read_arb_cycle: grant=%b m_arvalid=%b expected 00/0", arb_grant, m_axi_arvalid);
        end
        @(negedge clk);
        checks++;
        if (arb_grant !== 2'b01 || arb_busy !== 1'b1) begin
            failures++;
            $display("FAIL read_grant: grant=%b busy=%b expected 01/1", arb_grant, arb_busy);
        end
        checks++;
        if (m_axi_araddr !== 32'h0000_1000 || m_axi_arvalid !== 1'b1) begin
            failures++;
            $display("FAIL read_araddr: araddr=%h arvalid=%b expected 00001000/1", m_axi_araddr, m_axi_arvalid);
        end
        m_axi_arready = 1'b1;
        #1;
        checks++;
        if (s_axi_arready !== 2'b01) begin
            failures++;
            $display("FAIL read_arready: arready=%b expected 01", s_axi_arready);
        end
        @(posedge clk); #1;
        s_axi_arvalid = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = 32'hDEAD_BEEF;
        m_axi_rresp   = 2'b00;
        @(negedge clk);
        checks++;
        if (s_axi_rvalid !== 2'b01 || s_axi_rdata !== {2{32'hDEAD_BEEF}}) begin
            failures++;
            $display("FAIL read_rdata: rvalid=%b rdata=%h expected 01/deadbeefdeadbeef", s_axi_rvalid, s_axi_rdata);
        end
        checks++;
        if (m_axi_rready !== 1'b1) begin
            failures++;
            $display("FAIL read_rready: m_rready=%b expected 1", m_axi_rready);
        end
        @(posedge clk); #1;
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        s_axi_rready = 2'b00;
        @(negedge clk);
        checks++;
        if (arb_busy !== 1'b0 || arb_grant !== 2'b00) begin
            failures++;
            $display("FAIL read_release: busy=%b grant=%b expected 0/00", arb_busy, arb_grant);
        end
    endtask

    task automatic test_alternating_writes();
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_owner;
        bit          found;
        apply_reset();
        @(posedge clk); #1;
        s_axi_awvalid = 2'b11;
        s_axi_wvalid  = 2'b11;
        s_axi_awaddr  = {32'h0000_0020, 32'h0000_0010};
        s_axi_wdata   = {32'h2222_2222, 32'h1111_1111};
        s_axi_wstrb   = 8'hFF;
        s_axi_bready  = 2'b11;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_addr  = (t % 2 == 0) ? 32'h10 : 32'h20;
            exp_data  = (t % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
            exp_owner = (t % 2 == 0) ? 2'b01 : 2'b10;
            found = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (m_axi_awvalid) begin found = 1'b1; break; end
            end
            checks++;
            if (!found) begin
                failures++;
                $display("FAIL alt_timeout: write %0d never forwarded", t);
            end
            checks++;
            if (m_axi_awaddr !== exp_addr || m_axi_wdata !== exp_data) begin
                failures++;
                $display("FAIL alt_order: write %0d addr=%h data=%h expected %h/%h", t, m_axi_awaddr, m_axi_wdata, exp_addr, exp_data);
            end
            checks++;
            if (s_axi_awready !== exp_owner || arb_grant !== exp_owner) begin
                failures++;
                $display("FAIL alt_awready: write %0d awready=%b grant=%b expected %b", t, s_axi_awready, arb_grant, exp_owner);
            end
            @(posedge clk); #1;
            m_axi_bvalid = 1'b1;
            @(negedge clk);
            checks++;
            if (s_axi_bvalid !== exp_owner) begin
                failures++;
                $display("FAIL alt_bvalid: write %0d bvalid=%b expected %b", t, s_axi_bvalid, exp_owner);
            end
            @(posedge clk); #1;
            m_axi_bvalid = 1'b0;
        end
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_read_before_write();
        @(posedge clk); #1;
        s_axi_arvalid = 2'b10;
        s_axi_araddr[63:32] = 32'h0000_0300;
        s_axi_awvalid = 2'b10;
        s_axi_awaddr[63:32] = 32'h0000_0304;
        s_axi_wvalid  = 2'b10;
        s_axi_wdata[63:32] = 32'h3333_3333;
        s_axi_wstrb[7:4]   = 4'hF;
        s_axi_rready  = 2'b10;
        s_axi_bready  = 2'b10;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (arb_grant !== 2'b10 || m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h300) begin
            failures++;
            $display("FAIL rw_read_first: grant=%b arvalid=%b araddr=%h expected 10/1/300", arb_grant, m_axi_arvalid, m_axi_araddr);
        end
        checks++;
        if (m_axi_awvalid !== 1'b0 || s_axi_awready !== 2'b00 || s_axi_wready !== 2'b00) begin
            failures++;
            $display("FAIL rw_aw_blocked: m_awvalid=%b awready=%b wready=%b expected 0/00/00", m_axi_awvalid, s_axi_awready, s_axi_wready);
        end
        m_axi_arready = 1'b1;
        @(posedge clk); #1;
        s_axi_arvalid = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = 32'h1234_5678;
        @(posedge clk); #1;
        m_axi_rvalid  = 1'b0;
        s_axi_rready  = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (arb_grant !== 2'b10 || m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 32'h304 || m_axi_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL rw_write_next: grant=%b awvalid=%b awaddr=%h arvalid=%b expected 10/1/304/0",
                     arb_grant, m_axi_awvalid, m_axi_awaddr, m_axi_arvalid);
        end
        @(posedge clk); #1;
        s_axi_awvalid = 2'b00;
        s_axi_wvalid  = 2'b00;
        m_axi_bvalid  = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_wready_delay();
        bit held;
        @(posedge clk); #1;
        s_axi_awvalid = 2'b01;
        s_axi_awaddr[31:0] = 32'h0000_0040;
        s_axi_wvalid  = 2'b01;
        s_axi_wdata[31:0]  = 32'hA5A5_A5A5;
        s_axi_wstrb[3:0]   = 4'b0011;
        s_axi_bready  = 2'b01;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (arb_grant !== 2'b01 || m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 32'h40) begin
            failures++;
            $display("FAIL delay_grant: grant=%b awvalid=%b awaddr=%h expected 01/1/40", arb_grant, m_axi_awvalid, m_axi_awaddr);
        end
        checks++;
        if (m_axi_wstrb !== 4'b0011 || m_axi_wdata !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL delay_wstrb: wstrb=%b wdata=%h expected 0011/a5a5a5a5", m_axi_wstrb, m_axi_wdata);
        end
        m_axi_awready = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 2'b00;
        m_axi_awready = 1'b0;
        held = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (arb_grant !== 2'b01 || m_axi_wvalid !== 1'b1 || s_axi_wready !== 2'b00) held = 1'b0;
        end
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL delay_hold: grant=%b wvalid=%b wready=%b expected 01/1/00 for 5 cycles", arb_grant, m_axi_wvalid, s_axi_wready);
        end
        m_axi_wready = 1'b1;
        @(posedge clk); #1;
        s_axi_wvalid = 2'b00;
        m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b00;
        @(negedge clk);
        checks++;
        if (s_axi_bvalid !== 2'b01 || s_axi_bresp[1:0] !== 2'b00 || arb_grant !== 2'b01) begin
            failures++;
            $display("FAIL delay_bresp: bvalid=%b bresp=%b grant=%b expected 01/00/01", s_axi_bvalid, s_axi_bresp, arb_grant);
        end
        @(posedge clk); #1;
        m_axi_bvalid = 1'b0;
        s_axi_bready = 2'b00;
        @(negedge clk);
        checks++;
        if (arb_grant !== 2'b00 || arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL delay_release: grant=%b busy=%b expected 00/0", arb_grant, arb_busy);
        end
    endtask

    task automatic test_reset_mid_write();
        @(posedge clk); #1;
        s_axi_awvalid = 2'b01;
        s_axi_awaddr[31:0] = 32'h0000_0050;
        s_axi_wvalid  = 2'b01;
        s_axi_wstrb[3:0] = 4'hF;
        s_axi_bready  = 2'b01;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m_axi_awvalid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: m_awvalid=%b expected 1", m_axi_awvalid);
        end
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || m_axi_bready !== 1'b0 || arb_grant !== 2'b00 || arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_m_side: awvalid=%b wvalid=%b bready=%b grant=%b busy=%b expected all 0",
                     m_axi_awvalid, m_axi_wvalid, m_axi_bready, arb_grant, arb_busy);
        end
        checks++;
        if (s_axi_awready !== 2'b00 || s_axi_wready !== 2'b00 || s_axi_bvalid !== 2'b00) begin
            failures++;
            $display("FAIL midrst_s_side: awready=%b wready=%b bvalid=%b expected 00", s_axi_awready, s_axi_wready, s_axi_bvalid);
        end
        clear_inputs();
        s_axi_arvalid = 2'b11;
        s_axi_rready  = 2'b11;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (arb_grant !== 2'b01) begin
            failures++;
            $display("FAIL midrst_first_win: grant=%b expected 01", arb_grant);
        end
        apply_reset();
    endtask

`ifdef RV32I_AXIL_ARB_PERF_EN
    task automatic test_perf();
        apply_reset();
        @(negedge clk);
        checks++;
        if (perf_grants !== 64'h0 || perf_wait !== 64'h0) begin
            failures++;
            $display("FAIL perf_reset: grants=%h wait=%h expected 0", perf_grants, perf_wait);
        end
        run_read(0, 32'h100, 32'h1);
        run_write(1, 32'h200, 32'h2);
        run_read(0, 32'h104, 32'h3);
        run_write(1, 32'h204, 32'h4);
        run_read(0, 32'h108, 32'h5);
        @(negedge clk);
        checks++;
        if (perf_grants[31:0] !== 32'd3 || perf_grants[63:32] !== 32'd2) begin
            failures++;
            $display("FAIL perf_grants: m0=%0d m1=%0d expected 3/2", perf_grants[31:0], perf_grants[63:32]);
        end
        checks++;
        if (!(perf_wait[31:0] >= 32'd1)) begin
            failures++;
            $display("FAIL perf_wait: m0=%0d expected at least 1", perf_wait[31:0]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_alternating_writes();
        test_read_before_write();
        test_wready_delay();
        test_reset_mid_write();
        run_read(1, 32'h0000_0400, 32'h0BAD_F00D);
`ifdef RV32I_AXIL_ARB_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
